uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Byte-stream command framer sitting directly downstream of the UART receiver in the FPGA tester. It consumes received bytes (one-cycle strobe plus data) and hunts for a sync byte. It assembles a frame of command, length, payload and XOR checksum, then presents the validated command to the tester core over a valid/ready handshake. Malformed, truncated or overrun frames are dropped and reported on an error strobe.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `MAX_PAYLOAD`, default 16: maximum payload bytes; also the payload buffer depth.
- `TIMEOUT_CYCLES`, default 27000: inter-byte timeout in clocks (1 ms at 27 MHz).
- `in_clk`, input, 1: single clock for the block.
- `in_rst`, input, 1: reset, asynchronous, active-low.
- `in_rx_ready`, input, 1: one-cycle strobe, byte available from the receiver.
- `in_rx_data`, input, 8: received byte, valid when `in_rx_ready`=1.
- `out_cmd_valid`, output, 1: complete, checksum-verified frame held.
- `in_cmd_ready`, input, 1: consumer accepts the frame.
- `out_cmd`, output, 8: command byte.
- `out_len`, output, LW=$clog2(MAX_PAYLOAD+1): payload length.
- `in_pl_addr`, input, $clog2(MAX_PAYLOAD): payload read address.
- `out_pl_data`, output, 8: payload byte at the registered address.
- `out_err_valid`, output, 1: one-cycle error strobe.
- `out_err_code`, output, 2: error code, valid with `out_err_valid`.

## Operation
- States: `HUNT`, `CMD`, `LEN`, `PAYLOAD`, `CSUM`, `HOLD`.
- A byte is accepted only on a cycle with `in_rx_ready`=1.
- `HUNT`: a byte equal to `SYNC_BYTE` → `CMD`. Any other byte is discarded silently.
- `CMD`: store the byte; running checksum `csum` = byte → `LEN`.
- `LEN`:
  - If byte > `MAX_PAYLOAD`: error `ERR_LEN` → `HUNT`.
  - Otherwise store the length and XOR the byte into `csum`.
  - Length 0 → `CSUM`; otherwise → `PAYLOAD` with index 0.
- `PAYLOAD`: write the byte to `buf[index]`, XOR it into `csum`, increment index. When index reaches len−1 on acceptance → `CSUM`.
- `CSUM`:
  - Byte == `csum` → `HOLD`, assert `out_cmd_valid`.
  - Otherwise error `ERR_CSUM` → `HUNT`.
- `HOLD`:
  - `out_cmd`, `out_len` and the buffer are stable.
  - A byte arriving in `HOLD` is dropped with `ERR_OVERRUN`; the held frame is unaffected.
  - `out_cmd_valid`&&`in_cmd_ready` → `HUNT`.
- Timeout: a counter clears on every accepted byte and runs only in `CMD`, `LEN`, `PAYLOAD` and `CSUM`. When it reaches `TIMEOUT_CYCLES`−1: error `ERR_TIMEOUT` → `HUNT`. If a byte and the timeout occur in the same cycle, the byte wins and the counter clears.
- Error codes: `ERR_CSUM`=0, `ERR_LEN`=1, `ERR_TIMEOUT`=2, `ERR_OVERRUN`=3.
- `out_pl_data` = `buf[in_pl_addr]` when `in_pl_addr` < `out_len`, else 8'h00.

## Timing
- Reset values: state `HUNT`, `out_cmd_valid`=0, `out_cmd`=0, `out_len`=0, `out_pl_data`=0, `out_err_valid`=0, `out_err_code`=0, `csum`=0, timeout counter 0. Buffer contents are not reset.
- Reset asserted mid-frame or in `HOLD` drops the frame immediately, with no error strobe.
- `out_cmd_valid` rises in the cycle after the checksum byte strobe. It deasserts in the cycle after the valid&&ready handshake.
- `out_cmd_valid` never drops without a handshake.
- The earliest new frame byte is accepted in the cycle following the handshake.
- `out_err_valid` is registered: high for exactly one cycle, in the cycle after the triggering event.
- `out_pl_data` is registered: 1-cycle latency from `in_pl_addr`.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `uart_cmd_pkg` holds:
  - the state enum `cmd_state_t`;
  - the error-code enum `cmd_err_t` (2-bit);
  - the default `SYNC_BYTE` constant.
- Sub-module `cmd_payload_ram`: a 1-write/1-read, 8-bit × `MAX_PAYLOAD` register file with registered read, instantiated once.
- The FSM, checksum and timeout counter live in the top module.

## Test plan
- Send A5 10 02 11 22 21 with `in_cmd_ready`=0 → `out_cmd_valid`=1, `out_cmd`=10, `out_len`=2. Reading addresses 0/1/2 gives 11/22/00. Pulse ready → valid drops the next cycle.
- Send 33 A5 05 00 05 → leading 33 is ignored; a frame with cmd 05 and len 0 is presented, with no error.
- Send A5 10 02 11 22 20 → `out_err_valid` pulses with code 0 and `out_cmd_valid` stays 0. A following good frame is accepted.
- Send A5 07 11 (len 17 > 16) → code 1 one cycle after the len byte. The bytes that follow, until the next A5, are ignored.
- Send A5 10, then idle for 27000 cycles → code 2 exactly once. Repeat with a byte arriving on the final cycle → no error.
- With a frame held and ready=0, send 55 → code 3 while held data is unchanged. Assert reset mid-payload → all outputs at reset values and state `HUNT`.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types for the UART command framer: FSM states, error codes, default sync marker.
package uart_cmd_pkg;
  typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CSUM, HOLD} cmd_state_t;
  typedef enum logic [1:0] {
    ERR_CSUM    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } cmd_err_t;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/cmd_payload_ram.sv
// Payload buffer: one write port, one registered read port. Contents are not reset.
module cmd_payload_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          in_clk,
  input  logic          in_rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);
  logic [DEPTH-1:0][7:0] mem;

  always_ff @(posedge in_clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  always_ff @(posedge in_clk or negedge in_rst)
    if (!in_rst) rd_data <= '0;
    else         rd_data <= mem[rd_addr];
endmodule

// File: rtl/uart_cmd_parser.sv
// Frames sync/cmd/len/payload/xor-checksum from the UART byte stream and holds
// each verified command until the tester core accepts it.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         TIMEOUT_CYCLES = 27000,
  localparam int        LW             = $clog2(MAX_PAYLOAD + 1),
  localparam int        AW             = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic          in_clk,
  input  logic          in_rst,
  input  logic          in_rx_ready,
  input  logic [7:0]    in_rx_data,
  output logic          out_cmd_valid,
  input  logic          in_cmd_ready,
  output logic [7:0]    out_cmd,
  output logic [LW-1:0] out_len,
  input  logic [AW-1:0] in_pl_addr,
  output logic [7:0]    out_pl_data,
  output logic          out_err_valid,
  output logic [1:0]    out_err_code
);
  localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN = 8'(MAX_PAYLOAD);

  cmd_state_t    state, state_nxt;
  cmd_err_t      err_nxt, err_code_q;
  logic          err_set, err_q, valid_q;
  logic [7:0]    csum_q, cmd_q, ram_rd;
  logic [LW-1:0] len_q;
  logic [AW-1:0] idx_q;
  logic [TW-1:0] to_cnt;
  logic          timed, to_hit, last_pl, rd_ok_q;

  assign timed   = state inside {CMD, LEN, PAYLOAD, CSUM};
  // A byte arriving on the expiry cycle wins over the timeout.
  assign to_hit  = timed && !in_rx_ready && (to_cnt == TO_LAST);
  assign last_pl = (LW'(idx_q) == len_q - LW'(1));

  always_ff @(posedge in_clk or negedge in_rst)
    if (!in_rst) state <= HUNT;
    else         state <= state_nxt;

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_nxt   = ERR_CSUM;
    if (to_hit) begin
      state_nxt = HUNT;
      err_set   = 1'b1;
      err_nxt   = ERR_TIMEOUT;
    end else if (in_rx_ready) begin
      case (state)
        HUNT:    if (in_rx_data == SYNC_BYTE) state_nxt = CMD;
        CMD:     state_nxt = LEN;
        LEN:
          if (in_rx_data > MAX_LEN) begin
            state_nxt = HUNT;
            err_set   = 1'b1;
            err_nxt   = ERR_LEN;
          end else if (in_rx_data == 8'h00) state_nxt = CSUM;
          else                              state_nxt = PAYLOAD;
        PAYLOAD: if (last_pl) state_nxt = CSUM;
        CSUM:
          if (in_rx_data == csum_q) state_nxt = HOLD;
          else begin
            state_nxt = HUNT;
            err_set   = 1'b1;
            err_nxt   = ERR_CSUM;
          end
        HOLD: begin
          err_set = 1'b1;
          err_nxt = ERR_OVERRUN;
        end
        default: state_nxt = HUNT;
      endcase
    end
    // Handshake releases the frame regardless of an overrun in the same cycle.
    if (state == HOLD && in_cmd_ready) state_nxt = HUNT;
  end

  always_ff @(posedge in_clk or negedge in_rst)
    if (!in_rst) begin
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_CSUM;
      csum_q     <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      to_cnt     <= '0;
      rd_ok_q    <= 1'b0;
    end else begin
      valid_q <= (state_nxt == HOLD);
      err_q   <= err_set;
      if (err_set) err_code_q <= err_nxt;
      if (in_rx_ready || !timed || to_hit) to_cnt <= '0;
      else                                 to_cnt <= to_cnt + TW'(1);
      if (in_rx_ready) begin
        case (state)
          CMD: begin
            cmd_q  <= in_rx_data;
            csum_q <= in_rx_data;
          end
          LEN:
            if (in_rx_data <= MAX_LEN) begin
              len_q  <= LW'(in_rx_data);
              csum_q <= csum_q ^ in_rx_data;
              idx_q  <= '0;
            end
          PAYLOAD: begin
            csum_q <= csum_q ^ in_rx_data;
            idx_q  <= idx_q + AW'(1);
          end
          default: ;
        endcase
      end
      rd_ok_q <= (LW'(in_pl_addr) < len_q);
    end

  cmd_payload_ram #(.DEPTH(MAX_PAYLOAD), .AW(AW)) u_ram (
    .in_clk  (in_clk),
    .in_rst  (in_rst),
    .wr_en   (in_rx_ready && state == PAYLOAD),
    .wr_addr (idx_q),
    .wr_data (in_rx_data),
    .rd_addr (in_pl_addr),
    .rd_data (ram_rd)
  );

  assign out_cmd_valid = valid_q;
  assign out_cmd       = cmd_q;
  assign out_len       = len_q;
  assign out_pl_data   = rd_ok_q ? ram_rd : 8'h00;
  assign out_err_valid = err_q;
  assign out_err_code  = err_code_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Frame-level reference model of the command framer, compared against the DUT every cycle.
module tb_uart_cmd_parser;
  localparam int MAXP = 16;
  localparam int T    = 27000;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b0;
  logic       in_rx_ready = 1'b0;
  logic [7:0] in_rx_data = 8'h00;
  logic       in_cmd_ready = 1'b0;
  logic [3:0] in_pl_addr = 4'h0;
  logic       out_cmd_valid, out_err_valid;
  logic [7:0] out_cmd, out_pl_data;
  logic [4:0] out_len;
  logic [1:0] out_err_code;

  uart_cmd_parser dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_rx_ready(in_rx_ready), .in_rx_data(in_rx_data),
    .out_cmd_valid(out_cmd_valid), .in_cmd_ready(in_cmd_ready), .out_cmd(out_cmd),
    .out_len(out_len), .in_pl_addr(in_pl_addr), .out_pl_data(out_pl_data),
    .out_err_valid(out_err_valid), .out_err_code(out_err_code)
  );

  always #5 in_clk = ~in_clk;

  int n_tests = 0, n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: frame kept as a byte list, validated when complete.
  logic       m_hunt, m_held;
  logic [7:0] m_frame[$];
  int         m_idle, m_len;
  logic [7:0] m_cmd;
  logic [7:0] m_buf[MAXP];
  logic       e_err, pl_chk;
  int         e_code;
  logic [7:0] e_pl;

  task automatic model_reset();
    m_hunt = 1'b1; m_held = 1'b0; m_frame.delete(); m_idle = 0;
    m_len = 0; m_cmd = 8'h00; e_err = 1'b0; e_code = 0; pl_chk = 1'b0; e_pl = 8'h00;
  endtask

  task automatic frame_check();
    int n = m_frame.size();
    logic [7:0] x = 8'h00;
    if (n == 2 && m_frame[1] > MAXP) begin
      e_err = 1'b1; e_code = 1; m_hunt = 1'b1;
    end else if (n >= 2 && n == int'(m_frame[1]) + 3) begin
      for (int i = 0; i < n - 1; i++) x ^= m_frame[i];
      m_hunt = 1'b1;
      if (x == m_frame[n-1]) begin
        m_held = 1'b1; m_cmd = m_frame[0]; m_len = m_frame[1];
        for (int i = 0; i < m_len; i++) m_buf[i] = m_frame[2+i];
      end else begin
        e_err = 1'b1; e_code = 0;
      end
    end
  endtask

  task automatic model_step(input logic rx, input logic [7:0] d, input logic rdy, input logic [3:0] a);
    e_err  = 1'b0;
    pl_chk = m_held;
    e_pl   = (int'(a) < m_len) ? m_buf[a] : 8'h00;
    if (m_held) begin
      if (rx) begin e_err = 1'b1; e_code = 3; end
      if (rdy) m_held = 1'b0;
    end else if (!m_hunt) begin
      if (rx) begin
        m_idle = 0; m_frame.push_back(d); frame_check();
      end else begin
        m_idle++;
        if (m_idle == T) begin e_err = 1'b1; e_code = 2; m_hunt = 1'b1; end
      end
    end else if (rx && d == 8'hA5) begin
      m_hunt = 1'b0; m_frame.delete(); m_idle = 0;
    end
  endtask

  // One clock: drive inputs, step model at the edge, return at the following negedge.
  task automatic cyc(input logic rx, input logic [7:0] d, input logic rdy, input logic [3:0] a);
    in_rx_ready = rx; in_rx_data = d; in_cmd_ready = rdy; in_pl_addr = a;
    @(posedge in_clk);
    model_step(rx, d, rdy, a);
    @(negedge in_clk);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 4'h0);
  endtask

  task automatic idle(input logic rdy, input logic [3:0] a);
    cyc(1'b0, 8'h00, rdy, a);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    in_rst = 1'b0; in_rx_ready = 1'b0; in_cmd_ready = 1'b0; in_pl_addr = 4'h0;
    model_reset();
    @(negedge in_clk);
    chk("rst_valid", out_cmd_valid, 0);
    chk("rst_cmd", out_cmd, 0);
    chk("rst_len", out_len, 0);
    chk("rst_pl", out_pl_data, 0);
    chk("rst_err_v", out_err_valid, 0);
    chk("rst_err_c", out_err_code, 0);
    in_rst = 1'b1;
    chk_en = 1'b1;
  endtask

  always @(negedge in_clk) if (chk_en) begin
    chk("valid", out_cmd_valid, m_held);
    chk("err_valid", out_err_valid, e_err);
    if (e_err) chk("err_code", out_err_code, e_code);
    if (m_held) begin
      chk("cmd", out_cmd, m_cmd);
      chk("len", out_len, m_len);
    end
    if (pl_chk) chk("pl_data", out_pl_data, e_pl);
  end

  logic [7:0] q[$];

  task automatic gen_frame();
    int k = $urandom_range(0, 9);
    int L;
    logic [7:0] c, x;
    c = 8'($urandom);
    if (k <= 6) begin
      L = $urandom_range(0, MAXP);
      x = c ^ 8'(L);
      q.push_back(8'hA5); q.push_back(c); q.push_back(8'(L));
      for (int i = 0; i < L; i++) begin
        logic [7:0] p = 8'($urandom);
        q.push_back(p); x ^= p;
      end
      if (k == 6) x ^= 8'(1 << $urandom_range(0, 7));
      q.push_back(x);
    end else if (k == 7) begin
      q.push_back(8'hA5); q.push_back(c); q.push_back(8'($urandom_range(MAXP + 1, 255)));
      q.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < $urandom_range(1, 3); i++) q.push_back(8'($urandom));
    end
  endtask

  initial begin
    int errs, at, code;
    model_reset();
    repeat (2) @(negedge in_clk);
    do_reset();

    // Good frame held with ready low, then payload reads and an overrun.
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
    chk("t1_valid", out_cmd_valid, 1);
    chk("t1_cmd", out_cmd, 8'h10);
    chk("t1_len", out_len, 2);
    chk("t1_model_held", m_held, 1);
    idle(1'b0, 4'h0); chk("t1_pl0", out_pl_data, 8'h11);
    idle(1'b0, 4'h1); chk("t1_pl1", out_pl_data, 8'h22);
    idle(1'b0, 4'h2); chk("t1_pl2", out_pl_data, 8'h00);
    cyc(1'b1, 8'h55, 1'b0, 4'h1);
    chk("ovr_err_v", out_err_valid, 1);
    chk("ovr_code", out_err_code, 3);
    chk("ovr_valid", out_cmd_valid, 1);
    chk("ovr_cmd", out_cmd, 8'h10);
    chk("ovr_pl1", out_pl_data, 8'h22);
    idle(1'b1, 4'h0);
    chk("t1_hs_drop", out_cmd_valid, 0);

    // Leading junk, zero-length frame.
    send(8'h33); send(8'hA5); send(8'h05); send(8'h00); send(8'h05);
    chk("t2_valid", out_cmd_valid, 1);
    chk("t2_cmd", out_cmd, 8'h05);
    chk("t2_len", out_len, 0);
    idle(1'b1, 4'h0);

    // Bad checksum, then a good frame.
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h20);
    chk("t3_err_v", out_err_valid, 1);
    chk("t3_code", out_err_code, 0);
    chk("t3_valid", out_cmd_valid, 0);
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
    chk("t3_valid2", out_cmd_valid, 1);
    idle(1'b1, 4'h0);

    // Oversized length; trailing bytes ignored until the next sync.
    send(8'hA5); send(8'h07); send(8'h11);
    chk("t4_err_v", out_err_valid, 1);
    chk("t4_code", out_err_code, 1);
    send(8'h10); send(8'h02);
    send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
    chk("t4_valid", out_cmd_valid, 1);
    chk("t4_cmd", out_cmd, 8'h01);
    idle(1'b1, 4'h0);

    // Inter-byte timeout fires exactly once, on the T-th idle cycle.
    send(8'hA5); send(8'h10);
    errs = 0; at = -1; code = -1;
    for (int i = 0; i < T + 5; i++) begin
      idle(1'b0, 4'h0);
      if (out_err_valid) begin errs++; at = i; code = out_err_code; end
    end
    chk("to_count", errs, 1);
    chk("to_cycle", at, T - 1);
    chk("to_code", code, 2);

    // Byte on the final cycle keeps the frame alive.
    send(8'hA5); send(8'h10);
    errs = 0;
    for (int i = 0; i < T - 1; i++) begin
      idle(1'b0, 4'h0);
      if (out_err_valid) errs++;
    end
    send(8'h00); if (out_err_valid) errs++;
    send(8'h10); if (out_err_valid) errs++;
    chk("to_late_errs", errs, 0);
    chk("to_late_valid", out_cmd_valid, 1);
    idle(1'b1, 4'h0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic rdy;
      logic [3:0] a;
      if (q.size() < 4) gen_frame();
      rdy = ($urandom_range(0, 2) == 0);
      a   = 4'($urandom);
      if ($urandom_range(0, 2) == 0) cyc(1'b1, q.pop_front(), rdy, a);
      else                           cyc(1'b0, 8'h00, rdy, a);
    end
    repeat (3) idle(1'b1, 4'h0);

    // Reset mid-payload drops the frame.
    send(8'hA5); send(8'h10); send(8'h04); send(8'h11);
    do_reset();
    send(8'hA5); send(8'h05); send(8'h00); send(8'h05);
    chk("post_rst_valid", out_cmd_valid, 1);
    chk("post_rst_cmd", out_cmd, 8'h05);
    idle(1'b1, 4'h0);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
